// File: rtl/icap_reboot_ctrl.sv
// -----------------------------------------------------------------------------
// icap_reboot_ctrl
//
// Arbitrated multiboot controller for the Spartan-6 ICAP primitive. Two
// requesters (host on port 0, watchdog on port 1) may ask for a reboot into a
// 24-bit boot address. The granted request is latched, and the complete IPROG
// word sequence is streamed into the ICAP while BUSY is honoured. This block
// is the only driver of the ICAP_SPARTAN6 instance.
//
// Ports
//   clk            single clock (also the ICAP CLK)
//   rst            synchronous, active-high reset
//   req0_valid/addr/ready   host request; port 0 wins any tie
//   req1_valid/addr/ready   watchdog request
//   icap_ce_n      ICAP CE, active low
//   icap_write_n   ICAP WRITE, 0 = write
//   icap_din       ICAP I bus, already in the bit-swapped form the primitive
//                  expects (no swap is performed here)
//   icap_busy      ICAP BUSY; the presented word is held while it is high
//   active         high while a sequence is in progress
//   grant_id       requester owning the current/last sequence
//   done           one-cycle pulse, sequence completed
//   error          one-cycle pulse, sequence aborted on BUSY timeout
//
// Every output comes straight from a register. Each state therefore computes
// the outputs of the phase it names, and those outputs are seen one cycle
// later (SETUP state -> setup outputs on the bus in the following cycle).
// -----------------------------------------------------------------------------
module icap_reboot_ctrl #(
  parameter int unsigned DUMMY_WORDS   = 4,         // 1..8 FFFF words before sync
  parameter int unsigned NOOP_WORDS    = 4,         // 1..8 NO-OP words after IPROG
  parameter logic [23:0] FALLBACK_ADDR = 24'h000000,
  parameter logic [7:0]  SPI_OPCODE    = 8'h0B,
  parameter int unsigned BUSY_TIMEOUT  = 255        // 1..65535 stall cycles
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  output logic [15:0] icap_din,
  input  logic        icap_busy,
  output logic        active,
  output logic        grant_id,
  output logic        done,
  output logic        error
);

  // Sequence geometry: dummies, 12 fixed configuration words, NO-OPs.
  localparam int unsigned NUM_WORDS  = DUMMY_WORDS + 12 + NOOP_WORDS;
  localparam logic [4:0]  LAST_IDX   = 5'(NUM_WORDS - 1);
  localparam logic [4:0]  DUMMY_N    = 5'(DUMMY_WORDS);
  localparam logic [16:0] TIMEOUT_W  = 17'(BUSY_TIMEOUT);
  localparam logic [15:0] NOOP_WORD  = 16'h2000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STREAM,
    HOLD,
    FINISH
  } state_e;

  state_e      state_q;
  logic [4:0]  idx_q;        // index of the word currently on icap_din
  logic [15:0] stall_q;      // consecutive BUSY cycles on the current word
  logic [23:0] boot_addr_q;

  logic        req0_ready_q;
  logic        req1_ready_q;
  logic        icap_ce_n_q;
  logic        icap_write_n_q;
  logic [15:0] icap_din_q;
  logic        active_q;
  logic        grant_id_q;
  logic        done_q;
  logic        error_q;

  logic [4:0]  idx_d;
  logic [16:0] stall_d;      // one bit wider so the compare never wraps
  logic [15:0] next_word;
  logic [15:0] first_word;

  // Word table in the bit-swapped form the primitive consumes.
  function automatic logic [15:0] seq_word(input logic [4:0]  idx,
                                           input logic [23:0] addr);
    logic [4:0]  rel;
    logic [15:0] w;
    rel = idx - DUMMY_N;
    if (idx < DUMMY_N) begin
      w = 16'hFFFF;                                  // dummy pad
    end else begin
      case (rel)
        5'd0:    w = 16'hAA99;                       // sync word 1
        5'd1:    w = 16'h5566;                       // sync word 2
        5'd2:    w = 16'h3261;                       // write GENERAL1
        5'd3:    w = addr[15:0];                     // multiboot addr low
        5'd4:    w = 16'h3281;                       // write GENERAL2
        5'd5:    w = {SPI_OPCODE, addr[23:16]};      // opcode + addr high
        5'd6:    w = 16'h32A1;                       // write GENERAL3
        5'd7:    w = FALLBACK_ADDR[15:0];            // golden addr low
        5'd8:    w = 16'h32C1;                       // write GENERAL4
        5'd9:    w = {SPI_OPCODE, FALLBACK_ADDR[23:16]};
        5'd10:   w = 16'h30A1;                       // write CMD
        5'd11:   w = 16'h000E;                       // IPROG
        default: w = NOOP_WORD;                      // trailing NO-OPs
      endcase
    end
    return w;
  endfunction

  assign idx_d      = idx_q + 5'd1;
  assign stall_d    = {1'b0, stall_q} + 17'd1;
  assign next_word  = seq_word(idx_d, boot_addr_q);
  assign first_word = seq_word(5'd0, boot_addr_q);

  // NOTE: state and output registers use non-blocking assignments so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      stall_q        <= '0;
      boot_addr_q    <= '0;
      req0_ready_q   <= 1'b0;
      req1_ready_q   <= 1'b0;
      icap_ce_n_q    <= 1'b1;
      icap_write_n_q <= 1'b1;
      icap_din_q     <= NOOP_WORD;
      active_q       <= 1'b0;
      grant_id_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are raised only by the state that
      // owns them, which keeps every pulse exactly one cycle wide.
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req0_valid) begin
            req0_ready_q <= 1'b1;
            boot_addr_q  <= req0_addr;
            grant_id_q   <= 1'b0;
            active_q     <= 1'b1;
            state_q      <= SETUP;
          end else if (req1_valid) begin
            req1_ready_q <= 1'b1;
            boot_addr_q  <= req1_addr;
            grant_id_q   <= 1'b1;
            active_q     <= 1'b1;
            state_q      <= SETUP;
          end
        end

        SETUP: begin
          // WRITE goes low one cycle before CE so it never moves under CE.
          icap_write_n_q <= 1'b0;
          icap_ce_n_q    <= 1'b1;
          idx_q          <= '0;
          stall_q        <= '0;
          state_q        <= STREAM;
        end

        STREAM: begin
          if (icap_ce_n_q) begin
            // Setup phase is on the bus: present word 0 next.
            icap_ce_n_q <= 1'b0;
            icap_din_q  <= first_word;
          end else if (!icap_busy) begin
            // Presented word accepted this cycle.
            stall_q <= '0;
            if (idx_q == LAST_IDX) begin
              icap_ce_n_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              idx_q      <= idx_d;
              icap_din_q <= next_word;
            end
          end else if (stall_d == TIMEOUT_W) begin
            // Stalled too long: drop CE and WRITE together and give up.
            icap_ce_n_q    <= 1'b1;
            icap_write_n_q <= 1'b1;
            error_q        <= 1'b1;
            active_q       <= 1'b0;
            stall_q        <= '0;
            idx_q          <= '0;
            state_q        <= IDLE;
          end else begin
            stall_q <= stall_d[15:0];
          end
        end

        HOLD: begin
          // CE is already high; release WRITE and report completion.
          icap_write_n_q <= 1'b1;
          done_q         <= 1'b1;
          state_q        <= FINISH;
        end

        FINISH: begin
          active_q <= 1'b0;
          state_q  <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready   = req0_ready_q;
  assign req1_ready   = req1_ready_q;
  assign icap_ce_n    = icap_ce_n_q;
  assign icap_write_n = icap_write_n_q;
  assign icap_din     = icap_din_q;
  assign active       = active_q;
  assign grant_id     = grant_id_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icap_reboot_ctrl
//
// Scoreboard bench. Stimulus pushes a job (requester, address, expected grant
// cycle, BUSY plan) when it raises a request. The monitor pops the job when a
// ready strobe appears, expands it into the expected word list and end event,
// and compares every accepted ICAP word and every done/error pulse. A small
// BUSY driver raises icap_busy on the word named by the job's plan.
// -----------------------------------------------------------------------------
module tb_icap_reboot_ctrl;

  localparam int          DUMMY = 4;
  localparam int          NOOP  = 4;
  localparam int          NUM   = DUMMY + 12 + NOOP;
  localparam int          TMO   = 8;
  localparam logic [7:0]  SPI   = 8'h0B;
  localparam logic [23:0] FB    = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [23:0] req0_addr  = '0;
  logic        req1_valid = 1'b0;
  logic [23:0] req1_addr  = '0;
  logic        icap_busy  = 1'b0;
  logic        req0_ready, req1_ready, icap_ce_n, icap_write_n;
  logic [15:0] icap_din;
  logic        active, grant_id, done, error;

  icap_reboot_ctrl #(
    .DUMMY_WORDS  (DUMMY),
    .NOOP_WORDS   (NOOP),
    .FALLBACK_ADDR(FB),
    .SPI_OPCODE   (SPI),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_ready  (req1_ready),
    .icap_ce_n   (icap_ce_n),
    .icap_write_n(icap_write_n),
    .icap_din    (icap_din),
    .icap_busy   (icap_busy),
    .active      (active),
    .grant_id    (grant_id),
    .done        (done),
    .error       (error)
  );

  initial forever #5 clk = ~clk;

  // exp_cyc < 0: request waits behind a running sequence and is granted
  // relative to that sequence's end.
  typedef struct {
    bit          id;
    int          exp_cyc;
    logic [23:0] addr;
    int          sw;      // word index on which BUSY is raised
    int          sl;      // number of consecutive BUSY cycles
  } job_t;

  job_t        job_q[$];
  job_t        mj;
  logic [15:0] word_q[$];
  logic [15:0] w9_q[$];
  logic [15:0] seen[32];
  int          hold_cnt[32];

  int total = 0, bad = 0;
  int cyc = 0, acc = 0, ends = 0, dones = 0, errs = 0;
  int exp_end_cyc = 0, last_end_cyc = 0, last_end_gap = 2, last_ready_cyc = 0;
  int exp_c = 0;
  bit exp_abort = 1'b0, in_seq = 1'b0;
  int plan_id = 0, plan_w = 0, plan_len = 0;
  int bfm_seen = 0, bfm_w = 0, bfm_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
  endtask

  // Reference word list built from the configuration-packet layout.
  function automatic logic [15:0] ref_word(input int k, input logic [23:0] a);
    logic [15:0] cfg[12];
    logic [23:0] fb;
    fb  = FB;
    cfg = '{16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281, {SPI, a[23:16]},
            16'h32A1, fb[15:0], 16'h32C1, {SPI, fb[23:16]}, 16'h30A1, 16'h000E};
    if (k < DUMMY)      return 16'hFFFF;
    if (k < DUMMY + 12) return cfg[k - DUMMY];
    return 16'h2000;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // BUSY driver: reacts to the word currently on the bus.
  initial forever begin
    @(posedge clk);
    #1;
    if (plan_id != bfm_seen) begin
      bfm_seen = plan_id;
      bfm_w    = plan_w;
      bfm_left = plan_len;
    end
    if (!icap_ce_n && acc == bfm_w && bfm_left > 0) begin
      icap_busy = 1'b1;
      bfm_left--;
    end else begin
      icap_busy = 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
      if (job_q.size() == 0) begin
        fail_evt("unexpected_grant");
      end else begin
        mj = job_q.pop_front();
        check("grant_onehot", {req1_ready, req0_ready}, mj.id ? 2'b10 : 2'b01);
        check("grant_id", grant_id, mj.id);
        check("active_at_grant", active, 1'b1);
        exp_c = (mj.exp_cyc < 0) ? last_end_cyc + last_end_gap : mj.exp_cyc;
        check("grant_cycle", cyc, exp_c);
        last_ready_cyc = cyc;
        exp_abort = (mj.sl >= TMO);
        word_q.delete();
        for (int k = 0; k < (exp_abort ? mj.sw : NUM); k++)
          word_q.push_back(ref_word(k, mj.addr));
        exp_end_cyc = exp_abort ? cyc + 2 + mj.sw + TMO : cyc + NUM + 3 + mj.sl;
        for (int k = 0; k < 32; k++) begin
          seen[k]     = 16'hxxxx;
          hold_cnt[k] = 0;
        end
        acc      = 0;
        in_seq   = 1'b1;
        plan_w   = mj.sw;
        plan_len = mj.sl;
        plan_id++;
      end
    end
    if (icap_ce_n === 1'b0) begin
      check("write_n_under_ce", icap_write_n, 1'b0);
      if (acc < 32) hold_cnt[acc]++;
      if (icap_busy == 1'b0) begin
        if (word_q.size() == 0) fail_evt("extra_word");
        else check($sformatf("word%0d", acc), icap_din, word_q.pop_front());
        if (acc < 32) seen[acc] = icap_din;
        acc++;
      end
    end
    if (done === 1'b1) begin
      if (!in_seq) begin
        fail_evt("unexpected_done");
      end else begin
        check("end_is_error", 1'b0, exp_abort);
        check("done_cycle", cyc, exp_end_cyc);
        check("words_left_at_done", word_q.size(), 0);
        check("ce_n_at_done", icap_ce_n, 1'b1);
        w9_q.push_back(seen[9]);
        last_end_cyc = cyc;
        last_end_gap = 2;
        in_seq = 1'b0;
        dones++;
        ends++;
      end
    end
    if (error === 1'b1) begin
      if (!in_seq) begin
        fail_evt("unexpected_error");
      end else begin
        check("end_is_error", 1'b1, exp_abort);
        check("error_cycle", cyc, exp_end_cyc);
        check("words_left_at_error", word_q.size(), 0);
        check("ce_n_at_error", icap_ce_n, 1'b1);
        check("write_n_at_error", icap_write_n, 1'b1);
        check("active_at_error", active, 1'b0);
        last_end_cyc = cyc;
        last_end_gap = 1;
        in_seq = 1'b0;
        errs++;
        ends++;
      end
    end
    if (rst) begin
      word_q.delete();
      in_seq   = 1'b0;
      plan_len = 0;
      plan_id++;
    end
  end

  task automatic check_reset_vals(input string p);
    check({p, "_ce_n"},     icap_ce_n,    1'b1);
    check({p, "_write_n"},  icap_write_n, 1'b1);
    check({p, "_din"},      icap_din,     16'h2000);
    check({p, "_active"},   active,       1'b0);
    check({p, "_grant_id"}, grant_id,     1'b0);
    check({p, "_done"},     done,         1'b0);
    check({p, "_error"},    error,        1'b0);
    check({p, "_ready"},    {req1_ready, req0_ready}, 2'b00);
  endtask

  // Hold requests until each is acknowledged (bounded).
  task automatic drive(input bit v0, input bit v1, input logic [23:0] a0, input logic [23:0] a1);
    req0_valid = v0;
    req0_addr  = a0;
    req1_valid = v1;
    req1_addr  = a1;
    for (int k = 0; k < 400 && (req0_valid || req1_valid); k++) begin
      @(posedge clk);
      #1;
      if (req0_ready) req0_valid = 1'b0;
      if (req1_ready) req1_valid = 1'b0;
    end
    check("grant_within_bound", {req1_valid, req0_valid}, 2'b00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_ends(input int n);
    for (int k = 0; k < 400 && ends < n; k++) begin
      @(posedge clk);
      #1;
    end
    check("end_within_bound", (ends >= n), 1'b1);
  endtask

  task automatic run_one(input bit id, input logic [23:0] a, input int sw, input int sl);
    int start;
    start = ends;
    job_q.push_back('{id: id, exp_cyc: cyc + 1, addr: a, sw: sw, sl: sl});
    drive(!id, id, a, a);
    wait_ends(start + 1);
  endtask

  int          start_ends, start_dones, start_errs, mode, sw0, sl0, sw1, sl1;
  logic [23:0] a0, a1;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_init");
    rst = 1'b0;

    // Plain host reboot, no BUSY.
    run_one(1'b0, 24'h080000, 0, 0);
    check("t1_done_latency", last_end_cyc - last_ready_cyc, 23);
    check("t1_w0", seen[0], 16'hFFFF);
    check("t1_w4", seen[4], 16'hAA99);
    check("t1_w9", seen[9], 16'h0B08);
    check("t1_w15", seen[15], 16'h000E);
    check("t1_w19", seen[19], 16'h2000);

    // Simultaneous requests: host first, watchdog after it finishes.
    w9_q.delete();
    start_ends = ends;
    job_q.push_back('{id: 1'b0, exp_cyc: cyc + 1, addr: 24'h100000, sw: 0, sl: 0});
    job_q.push_back('{id: 1'b1, exp_cyc: -1, addr: 24'h200000, sw: 0, sl: 0});
    drive(1'b1, 1'b1, 24'h100000, 24'h200000);
    wait_ends(start_ends + 2);
    check("t2_seq_count", w9_q.size(), 2);
    if (w9_q.size() == 2) begin
      check("t2_first_w9", w9_q[0], 16'h0B10);
      check("t2_second_w9", w9_q[1], 16'h0B20);
    end

    // BUSY for 3 cycles on word 7.
    run_one(1'b0, 24'h080000, 7, 3);
    check("t3_w7_hold", hold_cnt[7], 4);
    check("t3_done_latency", last_end_cyc - last_ready_cyc, 26);

    // BUSY stuck from word 3: abort after TMO stall cycles.
    start_dones = dones;
    start_errs  = errs;
    run_one(1'b0, 24'h123456, 3, 20);
    check("t4_error_count", errs - start_errs, 1);
    check("t4_no_done", dones - start_dones, 0);
    check("t4_error_latency", last_end_cyc - last_ready_cyc, 2 + 3 + TMO);
    run_one(1'b1, 24'h654321, 0, 0);
    check("t4_after_abort_done", dones - start_dones, 1);

    // Reset while word 10 is on the bus.
    job_q.push_back('{id: 1'b1, exp_cyc: cyc + 1, addr: 24'h3ABCDE, sw: 0, sl: 0});
    drive(1'b0, 1'b1, 24'h0, 24'h3ABCDE);
    for (int k = 0; k < 100 && !(acc == 10 && icap_ce_n == 1'b0); k++) begin
      @(posedge clk);
      #1;
    end
    check("t5_reached_word10", acc, 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("rst_mid");
    run_one(1'b1, 24'h040000, 0, 0);
    check("t5_w0", seen[0], 16'hFFFF);
    check("t5_w9", seen[9], 16'h0B04);

    // Watchdog request raised in the middle of a host sequence.
    start_ends = ends;
    job_q.push_back('{id: 1'b0, exp_cyc: cyc + 1, addr: 24'h0C0000, sw: 0, sl: 0});
    drive(1'b1, 1'b0, 24'h0C0000, 24'h0);
    repeat (8) @(posedge clk);
    #1;
    job_q.push_back('{id: 1'b1, exp_cyc: -1, addr: 24'h0D0000, sw: 0, sl: 0});
    drive(1'b0, 1'b1, 24'h0, 24'h0D0000);
    wait_ends(start_ends + 2);

    // Randomized traffic.
    for (int it = 0; it < 20; it++) begin
      mode = $urandom_range(0, 2);
      a0   = 24'($urandom);
      a1   = 24'($urandom);
      sw0  = $urandom_range(0, NUM - 1);
      sl0  = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
      sw1  = $urandom_range(0, NUM - 1);
      sl1  = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
      if (mode == 0) begin
        run_one(1'b0, a0, sw0, sl0);
      end else if (mode == 1) begin
        run_one(1'b1, a1, sw1, sl1);
      end else begin
        start_ends = ends;
        job_q.push_back('{id: 1'b0, exp_cyc: cyc + 1, addr: a0, sw: sw0, sl: sl0});
        job_q.push_back('{id: 1'b1, exp_cyc: -1, addr: a1, sw: sw1, sl: sl1});
        drive(1'b1, 1'b1, a0, a1);
        wait_ends(start_ends + 2);
      end
    end

    check("jobs_left", job_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
